// File: rtl/shift_issue_ctrl.sv
// Issue/retire wrapper around the registered 16-bit right-shift unit: accepts one request,
// holds shifter operands for SHIFT_LAT edges, clamps shamt>=16, builds {N,Z,C}. Perf counters: SHIFT_ISSUE_PERF_EN.
module shift_issue_ctrl #(
  parameter int unsigned SHIFT_LAT = 1,
  parameter int unsigned WIDTH     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [WIDTH-1:0] in_shamt,
  output logic [WIDTH-1:0] sh_inp,
  output logic [WIDTH-1:0] sh_shift,
  input  logic [WIDTH-1:0] sh_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_flags
`ifdef SHIFT_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] op_q;
  logic [3:0]       amt_q;
  logic             big_q;

  logic [WIDTH-1:0] cap_data;
  logic             cap_c;

  // Counts of 16 or more shift everything out: result is pure sign fill, carry is the sign bit.
  always_comb begin
    cap_data = big_q ? {WIDTH{op_q[WIDTH-1]}} : sh_out;
    if (big_q)
      cap_c = op_q[WIDTH-1];
    else if (amt_q == 4'd0)
      cap_c = 1'b0;
    else
      cap_c = op_q[amt_q - 4'd1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      big_q     <= 1'b0;
      in_ready  <= 1'b0;
      sh_inp    <= '0;
      sh_shift  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sh_inp   <= in_operand;
            sh_shift <= {{(WIDTH-4){1'b0}}, in_shamt[3:0]};
            op_q     <= in_operand;
            amt_q    <= in_shamt[3:0];
            big_q    <= |in_shamt[WIDTH-1:4];
            cnt      <= 3'(SHIFT_LAT);
            in_ready <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt <= 3'd1)
            state <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= cap_data;
          res_flags <= {cap_data[WIDTH-1], cap_data == '0, cap_c};
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_ISSUE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (res_valid && res_ready)
        perf_ops <= perf_ops + 32'd1;
      if (state == DONE && !res_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Directed bench for shift_issue_ctrl: one instance at SHIFT_LAT=1 and one at SHIFT_LAT=4,
// each fed by a behavioural registered arithmetic-right-shift model.
module tb_shift_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        drive_valid, sel, res_ready;
  logic [15:0] in_operand, in_shamt;

  logic        in_valid1, in_ready1, res_valid1;
  logic [15:0] sh_inp1, sh_shift1, sh_out1, res_data1;
  logic [2:0]  res_flags1;
  logic        in_valid4, in_ready4, res_valid4;
  logic [15:0] sh_inp4, sh_shift4, sh_out4, res_data4;
  logic [2:0]  res_flags4;
`ifdef SHIFT_ISSUE_PERF_EN
  logic [31:0] perf_ops1, perf_stall1, perf_ops4, perf_stall4;
`endif

  assign in_valid1 = drive_valid & ~sel;
  assign in_valid4 = drive_valid & sel;

  shift_issue_ctrl #(.SHIFT_LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_operand(in_operand), .in_shamt(in_shamt), .sh_inp(sh_inp1), .sh_shift(sh_shift1),
    .sh_out(sh_out1), .res_valid(res_valid1), .res_ready(res_ready), .res_data(res_data1),
    .res_flags(res_flags1)
`ifdef SHIFT_ISSUE_PERF_EN
    , .perf_ops(perf_ops1), .perf_stall(perf_stall1)
`endif
  );

  shift_issue_ctrl #(.SHIFT_LAT(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_operand(in_operand), .in_shamt(in_shamt), .sh_inp(sh_inp4), .sh_shift(sh_shift4),
    .sh_out(sh_out4), .res_valid(res_valid4), .res_ready(res_ready), .res_data(res_data4),
    .res_flags(res_flags4)
`ifdef SHIFT_ISSUE_PERF_EN
    , .perf_ops(perf_ops4), .perf_stall(perf_stall4)
`endif
  );

  function automatic logic [15:0] asr(input logic [15:0] x, input logic [15:0] s);
    return 16'($signed(x) >>> s[3:0]);
  endfunction

  logic [15:0] p4 [4];
  always @(posedge clk) begin
    sh_out1 <= asr(sh_inp1, sh_shift1);
    p4[0]   <= asr(sh_inp4, sh_shift4);
    p4[1]   <= p4[0];
    p4[2]   <= p4[1];
    p4[3]   <= p4[2];
  end
  assign sh_out4 = p4[3];

  logic        cur_in_ready, cur_res_valid;
  logic [15:0] cur_sh_inp, cur_sh_shift, cur_res_data;
  logic [2:0]  cur_res_flags;
  assign cur_in_ready  = sel ? in_ready4  : in_ready1;
  assign cur_res_valid = sel ? res_valid4 : res_valid1;
  assign cur_sh_inp    = sel ? sh_inp4    : sh_inp1;
  assign cur_sh_shift  = sel ? sh_shift4  : sh_shift1;
  assign cur_res_data  = sel ? res_data4  : res_data1;
  assign cur_res_flags = sel ? res_flags4 : res_flags1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Entered and left on a falling edge.
  task automatic run_op(input logic [15:0] op, input logic [15:0] sh, input logic [15:0] exp_d,
                        input logic [2:0] exp_f, input int hold);
    int  lat;
    int  n;
    bit  got;
`ifdef SHIFT_ISSUE_PERF_EN
    logic [31:0] ops0, stall0;
    ops0   = sel ? perf_ops4   : perf_ops1;
    stall0 = sel ? perf_stall4 : perf_stall1;
`endif
    lat = sel ? 5 : 2;
    res_ready   = (hold == 0);
    in_operand  = op;
    in_shamt    = sh;
    drive_valid = 1'b1;
    n = 0;
    while (!cur_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cur_in_ready) begin
      expire("accept");
      drive_valid = 1'b0;
      return;
    end
    @(negedge clk);
    drive_valid = 1'b0;
    chk("sh_inp", 32'(cur_sh_inp), 32'(op));
    chk("sh_shift", 32'(cur_sh_shift), {28'h0, sh[3:0]});
    chk("in_ready_busy", 32'(cur_in_ready), 32'd0);
    got = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (cur_res_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      expire("res_valid");
      res_ready = 1'b1;
      return;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("res_data", 32'(cur_res_data), 32'(exp_d));
    chk("res_flags", 32'(cur_res_flags), 32'(exp_f));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_state", {13'h0, cur_res_valid, cur_in_ready, cur_res_flags, cur_res_data},
          {13'h0, 1'b1, 1'b0, exp_f, exp_d});
`ifdef SHIFT_ISSUE_PERF_EN
      chk("perf_stall", (sel ? perf_stall4 : perf_stall1) - stall0, 32'(hold));
`endif
      res_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_hs", {30'h0, cur_res_valid, cur_in_ready}, 32'd1);
`ifdef SHIFT_ISSUE_PERF_EN
    chk("perf_ops", (sel ? perf_ops4 : perf_ops1) - ops0, 32'd1);
`endif
  endtask

  typedef struct {
    logic [15:0] op;
    logic [15:0] sh;
    logic [15:0] d;
    logic [2:0]  f;
    int          hold;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [15:0] bop [3];
    logic [15:0] bsh [3];
    logic [15:0] bexp [3];
    int  idx, nres, last_t;
    bit  acc, seen;

    vt[0] = '{16'h000B, 16'h0001, 16'h0005, 3'b001, 0};
    vt[1] = '{16'h8F00, 16'h0004, 16'hF8F0, 3'b100, 0};
    vt[2] = '{16'hFF80, 16'h0003, 16'hFFF0, 3'b100, 0};
    vt[3] = '{16'h0030, 16'h0010, 16'h0000, 3'b010, 0};
    vt[4] = '{16'h8001, 16'h0100, 16'hFFFF, 3'b101, 0};
    vt[5] = '{16'h1234, 16'h0000, 16'h1234, 3'b000, 5};
    vt[6] = '{16'h0001, 16'h0001, 16'h0000, 3'b011, 0};
    vt[7] = '{16'h8000, 16'h000F, 16'hFFFF, 3'b100, 0};
    vt[8] = '{16'h7FFF, 16'h000F, 16'h0000, 3'b011, 0};
    vt[9] = '{16'h00F0, 16'hFFFF, 16'h0000, 3'b010, 0};

    rst = 1'b1; drive_valid = 1'b0; sel = 1'b0; res_ready = 1'b1;
    in_operand = '0; in_shamt = '0;
    #1;
    chk("reset_state", {7'h0, in_ready1, res_valid1, res_flags1, res_data1, 4'h0},
        32'd0);
    chk("reset_sh", {sh_inp1, sh_shift1}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready1), 32'd1);

    for (int i = 0; i < 10; i++)
      run_op(vt[i].op, vt[i].sh, vt[i].d, vt[i].f, vt[i].hold);

    // In_valid held high across three requests; results must come out in order, 4 cycles apart.
    bop  = '{16'h000B, 16'h8F00, 16'h0100};
    bsh  = '{16'h0001, 16'h0004, 16'h0008};
    bexp = '{16'h0005, 16'hF8F0, 16'h0001};
    idx = 0; nres = 0; last_t = 0;
    in_operand = bop[0]; in_shamt = bsh[0]; drive_valid = 1'b1;
    for (int t = 0; t < 80 && nres < 3; t++) begin
      acc = drive_valid && in_ready1;
      if (res_valid1) begin
        chk("b2b_data", 32'(res_data1), 32'(bexp[nres]));
        if (nres > 0) chk("b2b_gap", 32'(t - last_t), 32'd4);
        last_t = t;
        nres++;
      end
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_operand = bop[idx]; in_shamt = bsh[idx];
        end else begin
          drive_valid = 1'b0;
        end
      end
    end
    drive_valid = 1'b0;
    chk("b2b_count", 32'(nres), 32'd3);
    repeat (2) @(negedge clk);

    // Reset two edges into WAIT on the SHIFT_LAT=4 instance.
    sel = 1'b1;
    in_operand = 16'h000B; in_shamt = 16'h0001; drive_valid = 1'b1;
    idx = 0;
    while (!in_ready4 && idx < 20) begin
      @(negedge clk);
      idx++;
    end
    if (!in_ready4) expire("u4_accept");
    @(negedge clk);
    drive_valid = 1'b0;
    chk("u4_sh_loaded", {sh_inp4, sh_shift4}, 32'h000B_0001);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_sh", {sh_inp4, sh_shift4}, 32'd0);
    chk("rst_async_ctl", {11'h0, in_ready4, res_valid4, res_flags4, res_data4}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid4) seen = 1'b1;
    end
    chk("no_res_after_rst", 32'(seen), 32'd0);
    run_op(16'h000B, 16'h0001, 16'h0005, 3'b001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
